// File: rtl/hdr_pair_aligner.sv
// Aligns short/long exposure pixel streams into frame-locked word pairs.
// Each channel is buffered in its own FIFO; pairs leave once both heads agree.
module hdr_pair_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         not_empty,
    output logic         ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_push;

    assign do_push   = push && ready;
    assign rdata     = mem[rd_ptr];
    assign not_empty = (count != '0);

    always_comb begin
        count_nxt = count;
        if (do_push && !pop)
            count_nxt = count + CNT_ONE;
        else if (!do_push && pop)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // ready is registered so it stays low throughout reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            ready <= (count_nxt != FULL);
        end
    end
endmodule

module hdr_pair_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  asi_snk_0_valid_i,
    input  logic [DATA_WIDTH-1:0] asi_snk_0_data_i,
    input  logic                  asi_snk_0_startofpacket_i,
    input  logic                  asi_snk_0_endofpacket_i,
    output logic                  asi_snk_0_ready_o,
    input  logic                  asi_snk_1_valid_i,
    input  logic [DATA_WIDTH-1:0] asi_snk_1_data_i,
    input  logic                  asi_snk_1_startofpacket_i,
    input  logic                  asi_snk_1_endofpacket_i,
    output logic                  asi_snk_1_ready_o,
    output logic                  aso_src_valid_o,
    output logic [DATA_WIDTH-1:0] aso_src_0_data_o,
    output logic [DATA_WIDTH-1:0] aso_src_1_data_o,
    output logic                  aso_src_startofpacket_o,
    output logic                  aso_src_endofpacket_o,
    output logic                  err_misalign_o,
    output logic [15:0]           frame_cnt_o
);
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic {SYNC, RUN} state_t;

    state_t        state;
    logic [EW-1:0] h0;
    logic [EW-1:0] h1;
    logic          ne0;
    logic          ne1;
    logic          pop0;
    logic          pop1;
    logic          emit;
    logic          mis;
    logic          sop0;
    logic          sop1;
    logic          eop0;
    logic          eop1;

    hdr_pair_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (asi_snk_0_valid_i),
        .wdata     ({asi_snk_0_startofpacket_i,
                     asi_snk_0_endofpacket_i,
                     asi_snk_0_data_i}),
        .pop       (pop0),
        .rdata     (h0),
        .not_empty (ne0),
        .ready     (asi_snk_0_ready_o)
    );

    hdr_pair_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (asi_snk_1_valid_i),
        .wdata     ({asi_snk_1_startofpacket_i,
                     asi_snk_1_endofpacket_i,
                     asi_snk_1_data_i}),
        .pop       (pop1),
        .rdata     (h1),
        .not_empty (ne1),
        .ready     (asi_snk_1_ready_o)
    );

    assign sop0 = h0[EW-1];
    assign eop0 = h0[EW-2];
    assign sop1 = h1[EW-1];
    assign eop1 = h1[EW-2];

    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        emit = 1'b0;
        mis  = 1'b0;
        unique case (state)
            SYNC: begin
                if (ne0 && ne1 && sop0 && sop1) begin
                    pop0 = 1'b1;
                    pop1 = 1'b1;
                    emit = 1'b1;
                end else begin
                    // drop mid-frame words until each head is a frame start
                    pop0 = ne0 && !sop0;
                    pop1 = ne1 && !sop1;
                end
            end
            RUN: begin
                if (ne0 && ne1) begin
                    if (sop0 == sop1 && eop0 == eop1) begin
                        pop0 = 1'b1;
                        pop1 = 1'b1;
                        emit = 1'b1;
                    end else begin
                        mis = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= SYNC;
            aso_src_valid_o         <= 1'b0;
            aso_src_0_data_o        <= '0;
            aso_src_1_data_o        <= '0;
            aso_src_startofpacket_o <= 1'b0;
            aso_src_endofpacket_o   <= 1'b0;
            err_misalign_o          <= 1'b0;
            frame_cnt_o             <= '0;
        end else begin
            if (emit)
                state <= RUN;
            else if (mis)
                state <= SYNC;
            aso_src_valid_o         <= emit;
            aso_src_startofpacket_o <= emit && sop0;
            aso_src_endofpacket_o   <= emit && eop0;
            err_misalign_o          <= mis;
            if (emit) begin
                aso_src_0_data_o <= h0[DATA_WIDTH-1:0];
                aso_src_1_data_o <= h1[DATA_WIDTH-1:0];
            end
            if (emit && eop0)
                frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_hdr_pair_aligner.sv
// Directed bench for hdr_pair_aligner: cycle table for a lockstep frame,
// then hand-built sequences for skew, resync, backpressure and reset.
module tb_hdr_pair_aligner;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, s0, e0, v1, s1, e1;
    logic [31:0] d0, d1;
    logic        rdy0, rdy1;
    logic        ov, osop, oeop, oerr;
    logic [31:0] od0, od1;
    logic [15:0] fcnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int err_cnt = 0;

    typedef struct {
        int          cyc;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        s;
        logic        e;
    } pair_t;
    pair_t outq[$];

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        s0, e0, v1;
        logic [31:0] d1;
        logic        s1, e1, xv;
        logic [31:0] x0, x1;
        logic        xs, xe;
    } vec_t;
    vec_t vec[7];

    hdr_pair_aligner #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk                       (clk),
        .reset_n                   (rst_n),
        .asi_snk_0_valid_i         (v0),
        .asi_snk_0_data_i          (d0),
        .asi_snk_0_startofpacket_i (s0),
        .asi_snk_0_endofpacket_i   (e0),
        .asi_snk_0_ready_o         (rdy0),
        .asi_snk_1_valid_i         (v1),
        .asi_snk_1_data_i          (d1),
        .asi_snk_1_startofpacket_i (s1),
        .asi_snk_1_endofpacket_i   (e1),
        .asi_snk_1_ready_o         (rdy1),
        .aso_src_valid_o           (ov),
        .aso_src_0_data_o          (od0),
        .aso_src_1_data_o          (od1),
        .aso_src_startofpacket_o   (osop),
        .aso_src_endofpacket_o     (oeop),
        .err_misalign_o            (oerr),
        .frame_cnt_o               (fcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov)
            outq.push_back('{cyc: cyc, d0: od0, d1: od1, s: osop, e: oeop});
        if (oerr)
            err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic a_v, input logic [31:0] a_d,
                        input logic a_s, input logic a_e,
                        input logic b_v, input logic [31:0] b_d,
                        input logic b_s, input logic b_e);
        v0 = a_v; d0 = a_d; s0 = a_s; e0 = a_e;
        v1 = b_v; d1 = b_d; s1 = b_s; e1 = b_e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_pair(input logic [31:0] b0, input logic [31:0] b1,
                             input int n);
        for (int k = 0; k < n; k++)
            step(1, b0 + k, k == 0, k == n - 1,
                 1, b1 + k, k == 0, k == n - 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string name, input int start, input int n,
                             input logic [31:0] b0, input logic [31:0] b1,
                             input bit has_eop);
        pair_t p;
        for (int k = 0; k < n; k++) begin
            if (start + k >= outq.size()) begin
                tests++;
                fails++;
                $display("FAIL %s: pair %0d missing, got %0d pairs",
                         name, k, outq.size());
            end else begin
                p = outq[start + k];
                check({name, " d0"}, p.d0, b0 + k);
                check({name, " d1"}, p.d1, b1 + k);
                check({name, " sop/eop"}, 32'({p.s, p.e}),
                      32'({k == 0, has_eop && k == n - 1}));
            end
        end
    endtask

    initial begin
        int t1;
        int acc;
        int e_base;
        logic rd;

        vec[0] = '{1, 32'h10, 1, 0, 1, 32'h20, 1, 0, 0, 32'h0,  32'h0,  0, 0};
        vec[1] = '{1, 32'h11, 0, 0, 1, 32'h21, 0, 0, 0, 32'h0,  32'h0,  0, 0};
        vec[2] = '{1, 32'h12, 0, 0, 1, 32'h22, 0, 0, 1, 32'h10, 32'h20, 1, 0};
        vec[3] = '{1, 32'h13, 0, 1, 1, 32'h23, 0, 1, 1, 32'h11, 32'h21, 0, 0};
        vec[4] = '{0, 32'h0,  0, 0, 0, 32'h0,  0, 0, 1, 32'h12, 32'h22, 0, 0};
        vec[5] = '{0, 32'h0,  0, 0, 0, 32'h0,  0, 0, 1, 32'h13, 32'h23, 0, 1};
        vec[6] = '{0, 32'h0,  0, 0, 0, 32'h0,  0, 0, 0, 32'h13, 32'h23, 0, 0};

        rst_n = 1'b0;
        v0 = 0; d0 = 0; s0 = 0; e0 = 0;
        v1 = 0; d1 = 0; s1 = 0; e1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'({rdy0, rdy1}), 32'h0);
        check("reset flags", 32'({ov, osop, oeop, oerr}), 32'h0);
        check("reset data", od0 | od1, 32'h0);
        check("reset fcnt", 32'(fcnt), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready after reset", 32'({rdy0, rdy1}), 32'h3);

        // lockstep frame, cycle exact
        for (int i = 0; i < 7; i++) begin
            v0 = vec[i].v0; d0 = vec[i].d0; s0 = vec[i].s0; e0 = vec[i].e0;
            v1 = vec[i].v1; d1 = vec[i].d1; s1 = vec[i].s1; e1 = vec[i].e1;
            check($sformatf("vec%0d flags", i), 32'({ov, osop, oeop}),
                  32'({vec[i].xv, vec[i].xs, vec[i].xe}));
            check($sformatf("vec%0d d0", i), od0, vec[i].x0);
            check($sformatf("vec%0d d1", i), od1, vec[i].x1);
            @(posedge clk);
            #1;
        end
        check("lockstep fcnt", 32'(fcnt), 32'h1);

        // channel 1 five cycles late
        outq.delete();
        for (int k = 0; k < 9; k++) begin
            if (k == 5)
                t1 = cyc;
            step(k < 4, 32'h10 + k, k == 0, k == 3,
                 k >= 5, 32'h20 + k - 5, k == 5, k == 8);
        end
        idle(4);
        check("skew count", 32'(outq.size()), 32'd4);
        chk_frame("skew", 0, 4, 32'h10, 32'h20, 1);
        if (outq.size() > 0)
            check("skew latency", 32'(outq[0].cyc), 32'(t1 + 2));
        check("skew fcnt", 32'(fcnt), 32'h2);

        // orphan words on channel 0 dropped while syncing
        do_reset();
        outq.delete();
        e_base = err_cnt;
        for (int k = 0; k < 7; k++)
            step(1, (k < 3) ? 32'h50 + k : 32'h10 + k - 3, k == 3, k == 6,
                 k < 4, 32'h20 + k, k == 0, k == 3);
        idle(4);
        check("orphan count", 32'(outq.size()), 32'd4);
        chk_frame("orphan", 0, 4, 32'h10, 32'h20, 1);
        check("orphan err", 32'(err_cnt - e_base), 32'd0);
        check("orphan fcnt", 32'(fcnt), 32'h1);

        // short frame on channel 1 forces a resync
        outq.delete();
        e_base = err_cnt;
        for (int k = 0; k < 4; k++)
            step(1, 32'h30 + k, k == 0, k == 3,
                 k < 3, 32'h40 + k, k == 0, k == 2);
        idle(4);
        send_pair(32'h60, 32'h70, 4);
        idle(4);
        check("mis count", 32'(outq.size()), 32'd6);
        chk_frame("mis broken", 0, 2, 32'h30, 32'h40, 0);
        chk_frame("mis next", 2, 4, 32'h60, 32'h70, 1);
        check("mis err", 32'(err_cnt - e_base), 32'd1);
        check("mis fcnt", 32'(fcnt), 32'h2);

        // channel 1 idle: channel 0 fills and stalls
        outq.delete();
        acc = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            rd = rdy0;
            step(1, 32'h100 + acc, acc == 0, acc == DEPTH - 1,
                 0, 0, 0, 0);
            if (rd)
                acc++;
        end
        check("full accepts", 32'(acc), 32'(DEPTH));
        check("full ready0", 32'(rdy0), 32'h0);
        check("full no output", 32'(outq.size()), 32'd0);
        for (int k = 0; k < DEPTH; k++)
            step(0, 0, 0, 0, 1, 32'h200 + k, k == 0, k == DEPTH - 1);
        idle(3);
        check("drain ready0", 32'(rdy0), 32'h1);
        check("drain count", 32'(outq.size()), 32'(DEPTH));
        chk_frame("drain", 0, DEPTH, 32'h100, 32'h200, 1);
        check("drain fcnt", 32'(fcnt), 32'h3);

        // reset mid-frame with channel 0 half full
        for (int k = 0; k < DEPTH / 2; k++)
            step(1, 32'h300 + k, k == 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst flags", 32'({ov, osop, oeop, oerr}), 32'h0);
        check("async rst data", od0 | od1, 32'h0);
        check("async rst fcnt", 32'(fcnt), 32'h0);
        check("async rst ready", 32'({rdy0, rdy1}), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst release ready", 32'({rdy0, rdy1}), 32'h3);
        outq.delete();
        e_base = err_cnt;
        send_pair(32'h500, 32'h400, 4);
        send_pair(32'h600, 32'h700, 1);
        send_pair(32'h601, 32'h701, 1);
        idle(4);
        check("post rst count", 32'(outq.size()), 32'd6);
        chk_frame("post rst", 0, 4, 32'h500, 32'h400, 1);
        chk_frame("one word a", 4, 1, 32'h600, 32'h700, 1);
        chk_frame("one word b", 5, 1, 32'h601, 32'h701, 1);
        check("post rst err", 32'(err_cnt - e_base), 32'd0);
        check("post rst fcnt", 32'(fcnt), 32'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hdr_pair_aligner.md
HDR_PAIR_ALIGNER -- requirements
Module: hdr_pair_aligner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width of each stream.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per channel FIFO; power of two, minimum 4.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports asi_snk_0_valid_i / asi_snk_1_valid_i  input  1  channel 0 (short exposure) / channel 1 (long exposure) word valid.
REQ-006 SHALL have ports asi_snk_0_data_i / asi_snk_1_data_i  input  DATA_WIDTH  channel pixel word.
REQ-007 SHALL have ports asi_snk_0_startofpacket_i / asi_snk_1_startofpacket_i  input  1  first word of frame.
REQ-008 SHALL have ports asi_snk_0_endofpacket_i / asi_snk_1_endofpacket_i  input  1  last word of frame.
REQ-009 SHALL have ports asi_snk_0_ready_o / asi_snk_1_ready_o  output  1  channel may accept a word this cycle.
REQ-010 SHALL have port aso_src_valid_o  output  1  aligned word pair valid.
REQ-011 SHALL have ports aso_src_0_data_o / aso_src_1_data_o  output  DATA_WIDTH  aligned channel 0 / channel 1 words.
REQ-012 SHALL have ports aso_src_startofpacket_o / aso_src_endofpacket_o  output  1  frame delimiters of the aligned pair.
REQ-013 SHALL have port err_misalign_o  output  1  one-cycle pulse on detected delimiter mismatch.
REQ-014 SHALL have port frame_cnt_o  output  16  count of aligned frames completed.

Function
REQ-015 SHALL accept a word on a channel when valid_i and ready_o are both 1; the word and its sop/eop SHALL be written into that channel's FIFO.
REQ-016 SHALL drive ready_o = 1 exactly when that channel's FIFO holds fewer than FIFO_DEPTH entries; a pop in the same cycle SHALL NOT raise ready_o when full.
REQ-017 SHALL implement states SYNC and RUN; SYNC after reset.
REQ-018 In SYNC, SHALL pop and discard the head of each non-empty FIFO whose head sop=0, independently per channel, with no output.
REQ-019 In SYNC, when both heads are present with sop=1, SHALL pop both, emit the pair, and enter RUN in that cycle.
REQ-020 In RUN, when both FIFOs are non-empty and head sop and eop flags are equal, SHALL pop both and emit the pair.
REQ-021 In RUN, when either FIFO is empty, SHALL pop nothing and emit nothing; the output stream has no backpressure.
REQ-022 In RUN, when both heads are present and sop or eop flags differ, SHALL pop nothing, pulse err_misalign_o for one cycle, and enter SYNC.
REQ-023 Emitted pair SHALL appear on registered outputs one cycle after the pop: valid=1, data from each head, sop/eop from channel 0 head; otherwise valid, sop and eop SHALL be 0 and data SHALL hold.
REQ-024 Latency: a word pair accepted in cycle N with both FIFOs previously empty SHALL appear at outputs in cycle N+2.
REQ-025 SHALL increment frame_cnt_o by 1 on each emitted pair with eop=1, wrapping 0xFFFF -> 0x0000.
REQ-026 An emitted pair with sop=1 and eop=1 (one-word frame) SHALL be legal, stay in RUN and count as one frame.

Reset
REQ-027 On reset_n=0, SHALL immediately clear both FIFOs, enter SYNC, and drive ready_o=0, aso_src_valid_o=0, sop=0, eop=0, data=0, err_misalign_o=0, frame_cnt_o=0.
REQ-028 On first clock after reset_n rises, ready_o SHALL be 1; a reset mid-frame SHALL discard all buffered words and resynchronise on the next sop pair.

Verification
REQ-029 Both channels send a 4-word frame (0x10..0x13 / 0x20..0x23) in lockstep -> four outputs pairs (0x10,0x20)..(0x13,0x23), sop on first, eop on last, first at N+2, frame_cnt_o=1.
REQ-030 Channel 1 starts 5 cycles late -> channel 0 buffers; output pairs identical to REQ-029 beginning 2 cycles after channel 1's first word.
REQ-031 Channel 0 sends 3 mid-frame words (sop=0) then a frame; channel 1 sends a frame -> 3 words dropped in SYNC, no err pulse, frame aligned correctly.
REQ-032 Channel 1 frame of 3 words vs channel 0 of 4 -> one err_misalign_o pulse at eop mismatch, return to SYNC, next frame pair aligned, frame_cnt_o unchanged for broken frame.
REQ-033 Channel 1 idle, channel 0 streams continuously -> after FIFO_DEPTH accepts, asi_snk_0_ready_o=0, no output, no overflow; channel 1 resumes -> ready returns.
REQ-034 reset_n asserted mid-frame with both FIFOs half-full -> all outputs 0 asynchronously; after release, no stale words emitted.
